// File: rtl/iob_native_bridge.sv
// Native-to-bus bridge: one native master routed to an instruction channel or
// one of N_DBUS address-decoded data channels, with an optional timeout.
module iob_native_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_DBUS  = 2,
  parameter int TIMEOUT = 0
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     cke_i,
  input  logic                     nat_valid_i,
  input  logic                     nat_instr_i,
  input  logic [ADDR_W-1:0]        nat_addr_i,
  input  logic [DATA_W-1:0]        nat_wdata_i,
  input  logic [DATA_W/8-1:0]      nat_wstrb_i,
  output logic [DATA_W-1:0]        nat_rdata_o,
  output logic                     nat_ready_o,
  output logic                     ibus_valid_o,
  output logic [ADDR_W-1:0]        ibus_addr_o,
  input  logic                     ibus_ready_i,
  input  logic                     ibus_rvalid_i,
  input  logic [DATA_W-1:0]        ibus_rdata_i,
  output logic [N_DBUS-1:0]        dbus_valid_o,
  output logic [ADDR_W-1:0]        dbus_addr_o,
  output logic [DATA_W-1:0]        dbus_wdata_o,
  output logic [DATA_W/8-1:0]      dbus_wstrb_o,
  input  logic [N_DBUS-1:0]        dbus_ready_i,
  input  logic [N_DBUS-1:0]        dbus_rvalid_i,
  input  logic [N_DBUS*DATA_W-1:0] dbus_rdata_i,
  output logic                     err_o
);
  localparam int SEL_W = (N_DBUS > 1) ? $clog2(N_DBUS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t             state;
  logic               instr_q;
  logic               read_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt;

  logic [SEL_W-1:0]   sel;
  logic               dec_err;
  logic               sel_ready;
  logic               sel_rvalid;
  logic [DATA_W-1:0]  sel_rdata;
  logic               tmo;

  always_comb begin
    sel = '0;
    if (N_DBUS > 1) sel = nat_addr_i[ADDR_W-1 -: SEL_W];
    dec_err = !nat_instr_i && (int'(sel) >= N_DBUS);
  end

  // Only the channel captured for the current transaction is ever listened to.
  always_comb begin
    if (instr_q) begin
      sel_ready  = ibus_ready_i;
      sel_rvalid = ibus_rvalid_i;
      sel_rdata  = ibus_rdata_i;
    end else begin
      sel_ready  = dbus_ready_i[sel_q];
      sel_rvalid = dbus_rvalid_i[sel_q];
      sel_rdata  = dbus_rdata_i[int'(sel_q)*DATA_W +: DATA_W];
    end
  end

  assign tmo = (TIMEOUT > 0) && (int'(cnt) + 1 >= TIMEOUT);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= IDLE;
      instr_q      <= 1'b0;
      read_q       <= 1'b0;
      sel_q        <= '0;
      cnt          <= '0;
      nat_rdata_o  <= '0;
      nat_ready_o  <= 1'b0;
      ibus_valid_o <= 1'b0;
      ibus_addr_o  <= '0;
      dbus_valid_o <= '0;
      dbus_addr_o  <= '0;
      dbus_wdata_o <= '0;
      dbus_wstrb_o <= '0;
      err_o        <= 1'b0;
    end else if (cke_i) begin
      case (state)
        IDLE: if (nat_valid_i) begin
          instr_q      <= nat_instr_i;
          read_q       <= nat_instr_i || (nat_wstrb_i == '0);
          sel_q        <= sel;
          cnt          <= '0;
          ibus_addr_o  <= nat_addr_i;
          dbus_addr_o  <= nat_addr_i;
          dbus_wdata_o <= nat_wdata_i;
          dbus_wstrb_o <= nat_wstrb_i;
          if (dec_err) begin
            nat_rdata_o <= '0;
            state       <= DONE;
          end else begin
            if (nat_instr_i) ibus_valid_o <= 1'b1;
            else             dbus_valid_o <= N_DBUS'(1) << sel;
            state <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          // A write accepted in the last allowed cycle still completes; a read does not.
          if (sel_ready && !read_q) begin
            ibus_valid_o <= 1'b0;
            dbus_valid_o <= '0;
            nat_ready_o  <= 1'b1;
            state        <= DONE;
          end else if (tmo) begin
            ibus_valid_o <= 1'b0;
            dbus_valid_o <= '0;
            nat_rdata_o  <= '0;
            nat_ready_o  <= 1'b1;
            err_o        <= 1'b1;
            state        <= DONE;
          end else if (sel_ready) begin
            ibus_valid_o <= 1'b0;
            dbus_valid_o <= '0;
            state        <= RESP;
          end
        end
        RESP: begin
          cnt <= cnt + CNT_W'(1);
          if (sel_rvalid) begin
            nat_rdata_o <= sel_rdata;
            nat_ready_o <= 1'b1;
            state       <= DONE;
          end else if (tmo) begin
            nat_rdata_o <= '0;
            nat_ready_o <= 1'b1;
            err_o       <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Decode errors enter DONE with ready low and raise it one cycle later.
          if (nat_ready_o) begin
            nat_ready_o <= 1'b0;
            err_o       <= 1'b0;
            state       <= IDLE;
          end else begin
            nat_ready_o <= 1'b1;
            err_o       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iob_native_bridge.sv
// Randomized scoreboard bench for iob_native_bridge (3 data channels, timeout 8).
module tb_iob_native_bridge;
  localparam int NCH = 3;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        arst, cke;
  logic        nat_valid, nat_instr;
  logic [31:0] nat_addr, nat_wdata;
  logic [3:0]  nat_wstrb;
  logic [31:0] nat_rdata;
  logic        nat_ready;
  logic        ibus_valid;
  logic [31:0] ibus_addr;
  logic        ibus_ready, ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [2:0]  dbus_valid;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic [2:0]  dbus_ready, dbus_rvalid;
  logic [95:0] dbus_rdata;
  logic        err;

  iob_native_bridge #(.ADDR_W(32), .DATA_W(32), .N_DBUS(NCH), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .nat_valid_i(nat_valid), .nat_instr_i(nat_instr), .nat_addr_i(nat_addr),
    .nat_wdata_i(nat_wdata), .nat_wstrb_i(nat_wstrb),
    .nat_rdata_o(nat_rdata), .nat_ready_o(nat_ready),
    .ibus_valid_o(ibus_valid), .ibus_addr_o(ibus_addr),
    .ibus_ready_i(ibus_ready), .ibus_rvalid_i(ibus_rvalid), .ibus_rdata_i(ibus_rdata),
    .dbus_valid_o(dbus_valid), .dbus_addr_o(dbus_addr), .dbus_wdata_o(dbus_wdata),
    .dbus_wstrb_o(dbus_wstrb), .dbus_ready_i(dbus_ready), .dbus_rvalid_i(dbus_rvalid),
    .dbus_rdata_i(dbus_rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t        q[$];
  int          tests = 0, fails = 0, cyc = 0;
  logic [31:0] model_rd = '0;
  logic [3:0]  exp_vld = '0;          // {ibus, dbus[2:0]}
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic bus_idle();
    ibus_ready = 0; ibus_rvalid = 0; ibus_rdata = '0;
    dbus_ready = '0; dbus_rvalid = '0; dbus_rdata = '0;
  endtask

  // Monitor: checks bus-side valids every cycle and pops the scoreboard on each ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("valid_vector", {28'd0, ibus_valid, dbus_valid}, {28'd0, exp_vld});
      if (exp_vld[3]) check("ibus_addr", ibus_addr, exp_addr);
      if (exp_vld[2:0] != 0) begin
        check("dbus_addr", dbus_addr, exp_addr);
        check("dbus_wdata", dbus_wdata, exp_wdata);
        check("dbus_wstrb", {28'd0, dbus_wstrb}, {28'd0, exp_wstrb});
      end
      check("err_without_ready", {31'd0, err & ~nat_ready}, 32'd0);
      if (nat_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_ready at cycle %0d: got ready=1 expected no response", cyc);
        end else begin
          e = q.pop_front();
          check("resp_cycle", cyc, e.cyc);
          check("resp_rdata", nat_rdata, e.rdata);
          check("resp_err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  // One native transaction plus the bus slave behaviour for it.
  // dr: cycles of valid before ready, dv: cycles from acceptance to rvalid,
  // s: cycles of cke low right after the request is captured.
  task automatic txn(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int dr, input int dv, input int s,
                     input logic [31:0] rd);
    bit   rd_op, derr, ok, stall, sr, sv;
    int   ch, done, last, ec, vend, t0;
    logic [3:0]  nrv, nrd;
    logic [31:0] sd;
    exp_t e;
    rd_op = instr || (wstrb == 0);
    ch    = instr ? 3 : int'(addr[31:30]);
    derr  = !instr && (ch >= NCH);
    if (derr) begin ok = 0; done = 2; end
    else if (rd_op) begin ok = (1 + dr + dv <= TMO); done = ok ? 2 + dr + dv : TMO + 1; end
    else begin ok = (1 + dr <= TMO); done = ok ? 2 + dr : TMO + 1; end
    last = done;
    if (!derr && rd_op && 1 + dr + dv > last) last = 1 + dr + dv;
    if (!derr && 1 + dr > last) last = 1 + dr;
    vend = (1 + dr < TMO) ? 1 + dr : TMO;
    e.err   = !ok;
    e.rdata = !ok ? 32'd0 : (rd_op ? rd : model_rd);
    model_rd = e.rdata;

    @(posedge clk); #1;
    t0 = cyc;
    e.cyc = t0 + done + s;
    q.push_back(e);
    nat_instr = instr; nat_addr = addr; nat_wdata = wdata; nat_wstrb = wstrb;
    exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb;
    for (int c = 0; c <= last + s; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      stall = (c >= 1) && (c <= s);
      ec    = (c > s) ? c - s : (c == 0 ? 0 : -1);
      cke   = !stall;
      nat_valid = (c <= done + s);
      nrv = 4'($urandom) & 4'($urandom);
      nrd = 4'($urandom) & 4'($urandom);
      if (!derr) begin nrv[ch] = 1'b0; nrd[ch] = 1'b0; end
      ibus_rvalid = nrv[3]; dbus_rvalid = nrv[2:0];
      ibus_ready  = nrd[3]; dbus_ready  = nrd[2:0];
      ibus_rdata  = $urandom;
      dbus_rdata  = {$urandom, $urandom, $urandom};
      exp_vld = '0;
      if (!derr) begin
        sr = stall || (ec == 1 + dr);
        sv = 0; sd = $urandom;
        if (rd_op && ec == 1 + dr + dv) begin sv = 1; sd = rd; end
        else if (ec >= 1 && ec <= 1 + dr && $urandom_range(0, 3) == 0) sv = 1;
        if (ch == 3) begin ibus_ready = sr; ibus_rvalid = sv; ibus_rdata = sd; end
        else begin dbus_ready[ch] = sr; dbus_rvalid[ch] = sv; dbus_rdata[ch*32 +: 32] = sd; end
        if (stall || (ec >= 1 && ec <= vend)) exp_vld = 4'b1 << ch;
      end
    end
    @(posedge clk); #1;
    nat_valid = 0; cke = 1; exp_vld = '0;
    bus_idle();
  endtask

  // Read to channel 0, reset while waiting for rvalid, then a stale rvalid.
  task automatic reset_mid();
    @(posedge clk); #1;
    nat_valid = 1; nat_instr = 0; nat_addr = 32'h0000_0010; nat_wdata = 32'h1111_2222;
    nat_wstrb = 0;
    exp_addr = 32'h0000_0010; exp_wdata = 32'h1111_2222; exp_wstrb = 0;
    @(posedge clk); #1;
    exp_vld = 4'b0001; dbus_ready = 3'b001;
    @(posedge clk); #1;
    exp_vld = '0; dbus_ready = '0;
    #1 arst = 1;
    #1;
    check("rst_mid_ready", {31'd0, nat_ready}, 32'd0);
    check("rst_mid_valids", {28'd0, ibus_valid, dbus_valid}, 32'd0);
    check("rst_mid_rdata", nat_rdata, 32'd0);
    check("rst_mid_addr", dbus_addr | ibus_addr, 32'd0);
    check("rst_mid_wdata", {dbus_wdata[31:4], dbus_wdata[3:0] | dbus_wstrb}, 32'd0);
    nat_valid = 0; model_rd = '0;
    @(posedge clk); #1 arst = 0;
    @(posedge clk); #1;
    dbus_rvalid = 3'b001; dbus_rdata[31:0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    check("rst_after_rdata", nat_rdata, 32'd0);
  endtask

  initial begin
    arst = 1; cke = 1; nat_valid = 0; nat_instr = 0; nat_addr = '0; nat_wdata = '0;
    nat_wstrb = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, nat_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", nat_rdata, 32'd0);
    check("rst_dbus_addr", dbus_addr, 32'd0);
    check("rst_ibus_addr", ibus_addr, 32'd0);
    arst = 0;

    txn(1, 32'h0000_0100, 32'h0, 4'h0, 2, 1, 0, 32'h0000_0013);
    txn(0, 32'h4000_0004, 32'hCAFE_F00D, 4'hF, 0, 1, 0, 32'h0);
    txn(0, 32'hC000_0000, 32'h0, 4'h0, 0, 1, 0, 32'h0);
    txn(0, 32'h0000_0000, 32'h0, 4'h0, 0, 20, 0, 32'h1234_5678);
    txn(0, 32'h8000_0008, 32'h0, 4'h0, 1, 2, 0, 32'hA5A5_0001);
    reset_mid();
    txn(0, 32'h0000_0020, 32'h0, 4'h0, 1, 1, 0, 32'h7777_0002);
    txn(0, 32'h4000_0040, 32'h0102_0304, 4'h3, 0, 1, 3, 32'h0);
    txn(0, 32'h0000_0044, 32'h0, 4'h1, 7, 1, 0, 32'h0);
    txn(0, 32'h0000_0048, 32'h0, 4'h0, 6, 1, 0, 32'h5555_AAAA);
    txn(0, 32'h0000_004C, 32'h0, 4'h0, 7, 1, 0, 32'h6666_BBBB);

    for (int i = 0; i < 200; i++) begin
      bit          instr;
      logic [3:0]  ws;
      instr = ($urandom_range(0, 3) == 0);
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      txn(instr, $urandom, $urandom, ws, $urandom_range(0, 9), $urandom_range(1, 9),
          ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
